// File: rtl/work_serial_sender_if.sv
// Work-unit load bus and UART line status between a controller (master) and work_serial_sender (slave).
interface work_serial_sender_if;
    localparam int unsigned WORD_W = 256;

    logic              load;
    logic [WORD_W-1:0] midstate;
    logic [WORD_W-1:0] data2;
    logic              TxD;
    logic              busy;
    logic              done;

    modport master (output load, midstate, data2, input TxD, busy, done);
    modport slave  (input load, midstate, data2, output TxD, busy, done);
endinterface

// File: rtl/work_serial_sender.sv
// UART 8N1 transmitter for one 512-bit work unit: midstate bytes 0-31, then data2 bytes 0-31, LSB first.
// Define WORK_SERIAL_SENDER_CHECKSUM_EN to append a 65th byte holding the XOR of the 64 payload bytes.
module work_serial_sender #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                clk,
    input  logic                reset_n,
    work_serial_sender_if.slave bus
);
    localparam int unsigned BAUD_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned FRAME_W = 512;
`ifdef WORK_SERIAL_SENDER_CHECKSUM_EN
    localparam int unsigned N_BYTES = 65;
`else
    localparam int unsigned N_BYTES = 64;
`endif
    localparam logic [6:0] LAST_BYTE = 7'(N_BYTES - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]         state,    state_nxt;
    logic [BAUD_W-1:0]  baud,     baud_nxt;
    logic [2:0]         bit_cnt,  bit_cnt_nxt;
    logic [6:0]         byte_cnt, byte_cnt_nxt;
    logic [FRAME_W-1:0] shadow,   shadow_nxt;
    logic               tx,       tx_nxt;
    logic               busy_q,   busy_nxt;
    logic               done_q,   done_nxt;
    logic [7:0]         cur_byte;
    logic [2:0]         bit_inc;
    logic               baud_end;
`ifdef WORK_SERIAL_SENDER_CHECKSUM_EN
    logic [7:0]         csum,     csum_nxt;

    // The shadow register has shifted out every payload byte by the time the checksum byte is sent.
    assign cur_byte = (byte_cnt == LAST_BYTE) ? csum : shadow[7:0];
`else
    assign cur_byte = shadow[7:0];
`endif

    assign bit_inc  = bit_cnt + 3'd1;
    assign baud_end = (baud == BAUD_LAST);

    assign bus.TxD  = tx;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            baud     <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shadow   <= '0;
            tx       <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef WORK_SERIAL_SENDER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            state    <= state_nxt;
            baud     <= baud_nxt;
            bit_cnt  <= bit_cnt_nxt;
            byte_cnt <= byte_cnt_nxt;
            shadow   <= shadow_nxt;
            tx       <= tx_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
`ifdef WORK_SERIAL_SENDER_CHECKSUM_EN
            csum     <= csum_nxt;
`endif
        end
    end

    // Next-state and registered-output computation; tx carries the level for the coming cycle.
    always_comb begin
        state_nxt    = state;
        baud_nxt     = baud;
        bit_cnt_nxt  = bit_cnt;
        byte_cnt_nxt = byte_cnt;
        shadow_nxt   = shadow;
        tx_nxt       = tx;
        busy_nxt     = busy_q;
        done_nxt     = 1'b0;
`ifdef WORK_SERIAL_SENDER_CHECKSUM_EN
        csum_nxt     = csum;
`endif

        if (state != S_IDLE) begin
            baud_nxt = baud_end ? '0 : baud + BAUD_W'(1);
        end

        case (state)
            S_IDLE: begin
                if (bus.load) begin
                    state_nxt    = S_START;
                    shadow_nxt   = {bus.data2, bus.midstate};
                    baud_nxt     = '0;
                    bit_cnt_nxt  = '0;
                    byte_cnt_nxt = '0;
                    tx_nxt       = 1'b0;
                    busy_nxt     = 1'b1;
`ifdef WORK_SERIAL_SENDER_CHECKSUM_EN
                    csum_nxt     = '0;
`endif
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_nxt = S_DATA;
                    tx_nxt    = cur_byte[0];
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    bit_cnt_nxt = bit_inc;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = S_STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        tx_nxt    = cur_byte[bit_inc];
                    end
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    if (byte_cnt == LAST_BYTE) begin
                        state_nxt = S_IDLE;
                        tx_nxt    = 1'b1;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt    = S_START;
                        byte_cnt_nxt = byte_cnt + 7'd1;
                        shadow_nxt   = {8'h00, shadow[FRAME_W-1:8]};
                        tx_nxt       = 1'b0;
`ifdef WORK_SERIAL_SENDER_CHECKSUM_EN
                        csum_nxt     = csum ^ shadow[7:0];
`endif
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end
endmodule
